// File: rtl/vga_coord_gen.sv
// VGA raster coordinate generator: pixel/line counters with registered sync, active and
// frame flags that always describe the coordinate pair presented in the same cycle.
module vga_coord_gen #(
  parameter int unsigned H_VISIBLE = 1280,
  parameter int unsigned H_FP      = 48,
  parameter int unsigned H_SYNC    = 112,
  parameter int unsigned H_BP      = 248,
  parameter int unsigned V_VISIBLE = 1024,
  parameter int unsigned V_FP      = 1,
  parameter int unsigned V_SYNC    = 3,
  parameter int unsigned V_BP      = 38,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  input  logic        PIX_EN,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        FRAME_START,
  output logic [7:0]  FRAME_COUNT
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS      = 12'(V_VISIBLE);
  localparam logic [11:0] HS_START   = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_VISIBLE + V_FP + V_SYNC);

  logic [11:0] horz_d;
  logic [11:0] vert_d;
  logic        frame_wrap;
  logic        in_hsync;
  logic        in_vsync;
  logic        active_d;

  always_comb begin
    horz_d     = VGA_horzCoord;
    vert_d     = VGA_vertCoord;
    frame_wrap = 1'b0;
    if (PIX_EN) begin
      // >= rather than == so an out-of-range count can never run past the last column/line
      if (VGA_horzCoord >= H_LAST) begin
        horz_d = '0;
        if (VGA_vertCoord >= V_LAST) begin
          vert_d     = '0;
          frame_wrap = 1'b1;
        end else begin
          vert_d = VGA_vertCoord + 12'd1;
        end
      end else begin
        horz_d = VGA_horzCoord + 12'd1;
      end
    end
  end

  // Flags are decoded from the next coordinates so they register alongside them.
  always_comb begin
    in_hsync = (horz_d >= HS_START) && (horz_d < HS_END);
    in_vsync = (vert_d >= VS_START) && (vert_d < VS_END);
    active_d = (horz_d < H_VIS) && (vert_d < V_VIS);
  end

  always_ff @(posedge CLK_VGA or posedge RESET) begin
    if (RESET) begin
      VGA_horzCoord <= '0;
      VGA_vertCoord <= '0;
      VGA_HS        <= ~SYNC_POL;
      VGA_VS        <= ~SYNC_POL;
      VGA_active    <= 1'b1;
      FRAME_START   <= 1'b0;
      FRAME_COUNT   <= '0;
    end else begin
      VGA_horzCoord <= horz_d;
      VGA_vertCoord <= vert_d;
      VGA_HS        <= in_hsync ? SYNC_POL : ~SYNC_POL;
      VGA_VS        <= in_vsync ? SYNC_POL : ~SYNC_POL;
      VGA_active    <= active_d;
      FRAME_START   <= frame_wrap;
      if (frame_wrap) begin
        FRAME_COUNT <= FRAME_COUNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_coord_gen.sv
// Bench for vga_coord_gen: a small raster driven with random pixel enables, compared each
// cycle against a model that derives every output from the number of enabled steps taken.
module tb_vga_coord_gen;

  localparam int unsigned HV = 8, HFP = 1, HSY = 2, HBP = 2;
  localparam int unsigned VV = 5, VFP = 1, VSY = 2, VBP = 1;
  localparam int unsigned HT = HV + HFP + HSY + HBP;
  localparam int unsigned VT = VV + VFP + VSY + VBP;
  localparam int unsigned F  = HT * VT;
  localparam int unsigned K  = 257;
  localparam int unsigned TX = 3, TY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;

  logic [11:0] h1, v1, h0, v0;
  logic        hs1, vs1, act1, fs1, hs0, vs0, act0, fs0;
  logic [7:0]  fc1, fc0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n = 0;
  logic        fs_exp = 1'b0;
  int unsigned act_cnt, hs_cnt, vs_cnt, tgt_cnt, fs_cnt;

  always #5 clk = ~clk;

  vga_coord_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b1)
  ) dut_pos (
    .CLK_VGA(clk), .RESET(rst), .PIX_EN(pix_en),
    .VGA_horzCoord(h1), .VGA_vertCoord(v1), .VGA_HS(hs1), .VGA_VS(vs1),
    .VGA_active(act1), .FRAME_START(fs1), .FRAME_COUNT(fc1)
  );

  vga_coord_gen #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut_neg (
    .CLK_VGA(clk), .RESET(rst), .PIX_EN(pix_en),
    .VGA_horzCoord(h0), .VGA_vertCoord(v0), .VGA_HS(hs0), .VGA_VS(vs0),
    .VGA_active(act0), .FRAME_START(fs0), .FRAME_COUNT(fc0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, obs, exp, n);
    end
  endtask

  // Everything follows from n, the count of enabled steps since reset.
  function automatic logic [35:0] model(input bit pol);
    int unsigned h, v;
    logic hs, vs, act;
    logic [7:0] fc;
    h   = n % HT;
    v   = (n / HT) % VT;
    hs  = (h >= HV + HFP && h < HV + HFP + HSY) ? pol : !pol;
    vs  = (v >= VV + VFP && v < VV + VFP + VSY) ? pol : !pol;
    act = (h < HV) && (v < VV);
    fc  = 8'((n / F) % 256);
    return {fc, fs_exp, act, vs, hs, v[11:0], h[11:0]};
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_pol1"}, 64'({fc1, fs1, act1, vs1, hs1, v1, h1}), 64'(model(1'b1)));
    check({tag, "_pol0"}, 64'({fc0, fs0, act0, vs0, hs0, v0, h0}), 64'(model(1'b0)));
  endtask

  task automatic step(input bit en);
    if (en) begin
      if (act1) act_cnt++;
      if (hs1) hs_cnt++;
      if (vs1) vs_cnt++;
      if (h1 == 12'(TX) && v1 == 12'(TY) && act1) tgt_cnt++;
    end
    pix_en = en;
    @(posedge clk);
    if (en) n++;
    fs_exp = en && (n % F == 0);
    @(negedge clk);
    if (fs1) fs_cnt++;
    compare_all("scan");
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1;
    pix_en = 1'b0;
    n = 0;
    fs_exp = 1'b0;
    repeat (2) @(negedge clk);
    compare_all("reset_hold");
    rst = 1'b0;
  endtask

  initial begin
    int unsigned cycles;
    sync_reset();
    repeat (3) step(1'b0);
    repeat (HT + 5) step(1'b1);

    // Asynchronous reset between edges, mid-frame.
    repeat (30) step(1'b1);
    #2 rst = 1'b1;
    n = 0;
    fs_exp = 1'b0;
    #1 compare_all("async_reset");
    @(negedge clk);
    compare_all("reset_held");
    rst = 1'b0;
    step(1'b0);
    step(1'b1);
    check("first_step_h", 64'(h1), 64'd1);
    check("first_step_v", 64'(v1), 64'd0);

    sync_reset();
    act_cnt = 0; hs_cnt = 0; vs_cnt = 0; tgt_cnt = 0; fs_cnt = 0;
    repeat (5) step(1'b1);
    for (int i = 0; i < 4; i++) step(i % 2 == 0);
    check("toggle_h", 64'(h1), 64'd7);

    cycles = 0;
    while (n < K * F && cycles < 60000) begin
      step($urandom_range(0, 9) < 8);
      cycles++;
    end
    check("frames_reached", 64'(n), 64'(K * F));
    step(1'b0);
    check("hold_no_restart_pulse", 64'(fs1), 64'd0);
    check("frame_start_pulses", 64'(fs_cnt), 64'(K));
    check("frame_count_end", 64'(fc1), 64'(K % 256));
    check("active_pixels", 64'(act_cnt), 64'(K * HV * VV));
    check("hsync_cycles", 64'(hs_cnt), 64'(K * VT * HSY));
    check("vsync_cycles", 64'(vs_cnt), 64'(K * HT * VSY));
    check("target_once_per_frame", 64'(tgt_cnt), 64'(K));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_coord_gen.md
VGA_COORD_GEN -- requirements
Module: vga_coord_gen

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- H_VISIBLE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_VISIBLE, 1024, visible lines per frame
- V_FP, 1, vertical front porch
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- SYNC_POL, 1, sync active level (1 = active-high)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK_VGA, in, 1, pixel-domain clock (108 MHz for the default mode)
- RESET, in, 1, asynchronous, active-high reset
- PIX_EN, in, 1, pixel-advance enable; tie high for one pixel per clock
- VGA_horzCoord, out, 12, current pixel column
- VGA_vertCoord, out, 12, current line
- VGA_HS, out, 1, horizontal sync
- VGA_VS, out, 1, vertical sync
- VGA_active, out, 1, high inside the visible area
- FRAME_START, out, 1, one-cycle pulse at coordinate (0,0)
- FRAME_COUNT, out, 8, frames completed, free-running

REQ-003 There SHALL be one clock, CLK_VGA; RESET SHALL be asynchronous and active-high.

Function
REQ-004 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (default 1688); V_TOTAL SHALL equal V_VISIBLE+V_FP+V_SYNC+V_BP (default 1066).

REQ-005 VGA_horzCoord SHALL increment by 1 on each rising edge where PIX_EN=1 and hold when PIX_EN=0.

REQ-006 Horizontal wrap: at VGA_horzCoord=H_TOTAL-1 with PIX_EN=1, VGA_horzCoord SHALL become 0 and VGA_vertCoord SHALL advance by 1 in the same edge.

REQ-007 Vertical wrap: at (H_TOTAL-1, V_TOTAL-1) with PIX_EN=1, both coordinates SHALL become 0 in the same edge and FRAME_COUNT SHALL increment, wrapping from 255 to 0.

REQ-008 Coordinates SHALL never exceed H_TOTAL-1 and V_TOTAL-1; counter arithmetic is 12-bit unsigned.

REQ-009 All outputs SHALL be registered and mutually aligned: each flag describes the coordinate pair presented in the same cycle, with no combinational path from counters to outputs.

REQ-010 VGA_HS SHALL equal SYNC_POL when H_VISIBLE+H_FP <= VGA_horzCoord < H_VISIBLE+H_FP+H_SYNC (default 1328..1439), otherwise ~SYNC_POL.

REQ-011 VGA_VS SHALL equal SYNC_POL when V_VISIBLE+V_FP <= VGA_vertCoord < V_VISIBLE+V_FP+V_SYNC (default 1025..1027), otherwise ~SYNC_POL.

REQ-012 VGA_active SHALL be 1 exactly when VGA_horzCoord < H_VISIBLE and VGA_vertCoord < V_VISIBLE.

REQ-013 FRAME_START SHALL be 1 for exactly one clock, in the cycle the coordinates first become (0,0) after a vertical wrap.
- It SHALL stay low on further cycles while PIX_EN=0 holds (0,0).
- It SHALL stay low on release from reset.

REQ-014 Downstream glyph/overlay logic SHALL be able to compare the coordinates directly; a coordinate such as (250,950) SHALL be presented for exactly one PIX_EN-qualified cycle per frame.

Reset
REQ-015 While RESET=1, the outputs SHALL asynchronously take these values:
- VGA_horzCoord=0, VGA_vertCoord=0
- VGA_HS=~SYNC_POL, VGA_VS=~SYNC_POL
- VGA_active=1, FRAME_START=0, FRAME_COUNT=0

REQ-016 Reset asserted mid-line or mid-frame SHALL abort the scan immediately, without completing the line.

REQ-017 Counting SHALL resume from (0,0) on the first PIX_EN-qualified edge after RESET deasserts, advancing to (1,0).

Verification
REQ-018 Reset then PIX_EN=1 for 1688 clocks: horzCoord runs 0..1687, then 0; vertCoord goes 0->1; HS high for exactly 112 cycles starting at horzCoord=1328.

REQ-019 Run one full frame of 1688*1066=1,799,408 clocks:
- VS high on lines 1025..1027 only.
- FRAME_START pulses once, at the frame boundary.
- FRAME_COUNT goes 0->1.
- Active-pixel count is 1,310,720.

REQ-020 PIX_EN toggling 1,0,1,0 at horzCoord=100: coordinates hold while PIX_EN=0, reaching 102 after two enabled edges; all flags hold with the coordinates.

REQ-021 RESET asserted asynchronously at (700,500), between clock edges: outputs go to the reset values immediately; the first enabled edge after release gives (1,0).

REQ-022 Run 256 frames: FRAME_COUNT wraps 255->0 with FRAME_START still pulsing; coordinate (250,950) is seen exactly once per frame with VGA_active=1.

REQ-023 With SYNC_POL=0: HS and VS are inverted relative to REQ-018 and REQ-019, and all other behaviour is unchanged.
